// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - Shared defaults and types for the frame buffer write path.
package fb_pkg;

  localparam int DEF_H_RES  = 320;
  localparam int DEF_V_RES  = 200;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int FB_PIXELS  = DEF_H_RES * DEF_V_RES;

  typedef enum logic [1:0] {
    CLEAR,
    DRAW,
    SWAP_WAIT
  } writer_state_t;

  typedef struct packed {
    logic [8:0]            x;
    logic [7:0]            y;
    logic [DEF_DATA_W-1:0] color;
  } pixel_req_t;

endpackage

// File: rtl/fb_addr_calc.sv
// rtl/fb_addr_calc.sv - Combinational x/y to linear frame buffer address with range check.
module fb_addr_calc
  import fb_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [8:0]        x_i,
  input  logic [7:0]        y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_range_o
);

  logic [31:0] x_ext;
  logic [31:0] y_ext;

  assign x_ext = 32'(x_i);
  assign y_ext = 32'(y_i);

  // 320 = 256 + 64, so the default line width needs no multiplier.
  generate
    if (H_RES == 320) begin : g_shift_add
      assign addr_o = ADDR_W'((y_ext << 8) + (y_ext << 6) + x_ext);
    end else begin : g_mul
      assign addr_o = ADDR_W'(y_ext * 32'(H_RES) + x_ext);
    end
  endgenerate

  assign in_range_o = (x_ext < 32'(H_RES)) && (y_ext < 32'(V_RES));

endmodule

// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - Clears the back buffer, writes renderer pixels, requests the swap at vblank.
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] clear_color,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [8:0]        pix_x,
  input  logic [7:0]        pix_y,
  input  logic [DATA_W-1:0] pix_color,
  input  logic              frame_done,
  input  logic              FrameComplete,
  output logic              drawing,
  output logic              wren,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] frame_buffer_data,
  output logic              switch_buffer
);

  localparam int FB_PIX = H_RES * V_RES;
  localparam int CNT_W  = ADDR_W + 1;

  generate
    if (FB_PIX > (2 ** ADDR_W)) begin : g_size_check
      $error("frame_buffer_writer: H_RES*V_RES does not fit in ADDR_W");
    end
  endgenerate

  writer_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, drawing_q, switch_q;

  pixel_req_t        req;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_in_range;
  logic              hs;

  assign req = '{x: pix_x, y: pix_y, color: pix_color};
  assign hs  = pix_valid && ready_q;

  fb_addr_calc #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) u_addr_calc (
    .x_i       (req.x),
    .y_i       (req.y),
    .addr_o    (pix_addr),
    .in_range_o(pix_in_range)
  );

  // CLEAR spends one extra idle cycle at cnt==FB_PIX so every status output
  // can be registered from the next state without a one-cycle skew.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == CNT_W'(FB_PIX)) begin
          state_d = DRAW;
        end else begin
          wren_d = 1'b1;
          addr_d = ADDR_W'(cnt_q);
          data_d = color_q;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      DRAW: begin
        if (hs && pix_in_range) begin
          wren_d = 1'b1;
          addr_d = pix_addr;
          data_d = req.color;
        end
        if (frame_done) state_d = SWAP_WAIT;
      end
      SWAP_WAIT: begin
        if (FrameComplete) begin
          state_d = CLEAR;
          cnt_d   = '0;
          color_d = clear_color;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      color_q   <= clear_color;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      drawing_q <= 1'b0;
      switch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      color_q   <= color_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ready_q   <= (state_d == DRAW);
      drawing_q <= (state_d == DRAW);
      switch_q  <= (state_d == SWAP_WAIT);
    end
  end

  assign pix_ready         = ready_q;
  assign drawing           = drawing_q;
  assign wren              = wren_q;
  assign write_addr        = addr_q;
  assign frame_buffer_data = data_q;
  assign switch_buffer     = switch_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb/tb_frame_buffer_writer.sv - Scoreboard bench for frame_buffer_writer.
module tb_frame_buffer_writer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  clear_color;
  logic        pix_valid;
  logic        pix_ready;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic [7:0]  pix_color;
  logic        frame_done;
  logic        FrameComplete;
  logic        drawing;
  logic        wren;
  logic [15:0] write_addr;
  logic [7:0]  frame_buffer_data;
  logic        switch_buffer;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 CLK = ~CLK;

  frame_buffer_writer dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .clear_color      (clear_color),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .pix_x            (pix_x),
    .pix_y            (pix_y),
    .pix_color        (pix_color),
    .frame_done       (frame_done),
    .FrameComplete    (FrameComplete),
    .drawing          (drawing),
    .wren             (wren),
    .write_addr       (write_addr),
    .frame_buffer_data(frame_buffer_data),
    .switch_buffer    (switch_buffer)
  );

  // Every observed write must match the oldest expected write, in order.
  always @(negedge CLK) begin
    if (wren === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write got addr=%0d data=%h expected no write", write_addr, frame_buffer_data);
      end else begin
        exp_e = exp_q.pop_front();
        if (write_addr !== exp_e.addr || frame_buffer_data !== exp_e.data) begin
          n_fail++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                   write_addr, frame_buffer_data, exp_e.addr, exp_e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_wr(input int a, input int d);
    exp_q.push_back('{addr: 16'(a), data: 8'(d)});
  endtask

  task automatic test_reset();
    RESET = 1'b1; clear_color = 8'h1F;
    pix_valid = 1'b1; pix_x = 9'd0; pix_y = 8'd0; pix_color = 8'hEE;
    frame_done = 1'b0; FrameComplete = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if ({wren, pix_ready, drawing, switch_buffer} !== 4'b0000 || write_addr !== 16'd0 || frame_buffer_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_values got ctl=%b addr=%0d data=%h expected ctl=0000 addr=0 data=00",
               {wren, pix_ready, drawing, switch_buffer}, write_addr, frame_buffer_data);
    end
    RESET = 1'b0;
    for (int i = 0; i < 64000; i++) push_wr(i, 8'h1F);
    for (int i = 0; i < 64000; i++) begin
      frame_done    = (i == 100);
      FrameComplete = (i == 100);
      @(negedge CLK);
      n_checks++;
      if ({wren, pix_ready, drawing, switch_buffer} !== 4'b1000) begin
        n_fail++;
        $display("FAIL clear_ctl cycle=%0d got wren/ready/drawing/switch=%b expected 1000",
                 i, {wren, pix_ready, drawing, switch_buffer});
      end
    end
    @(negedge CLK);
    pix_valid = 1'b0;
    n_checks++;
    if ({wren, pix_ready, drawing, switch_buffer} !== 4'b0110) begin
      n_fail++;
      $display("FAIL draw_entry got wren/ready/drawing/switch=%b expected 0110",
               {wren, pix_ready, drawing, switch_buffer});
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL clear_count got %0d pending writes expected 0", exp_q.size());
    end
  endtask

  task automatic test_draw();
    pix_valid = 1'b1; pix_x = 9'd319; pix_y = 8'd199; pix_color = 8'hA5;
    push_wr(63999, 8'hA5);
    @(negedge CLK);
    n_checks++;
    if (wren !== 1'b1) begin
      n_fail++;
      $display("FAIL draw_last_pixel got wren=%b expected 1", wren);
    end
    pix_x = 9'd0; pix_y = 8'd1; pix_color = 8'h3C;
    push_wr(320, 8'h3C);
    @(negedge CLK);
    n_checks++;
    if (wren !== 1'b1) begin
      n_fail++;
      $display("FAIL draw_row1 got wren=%b expected 1", wren);
    end
    pix_valid = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (wren !== 1'b0 || pix_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL draw_idle got wren=%b ready=%b expected wren=0 ready=1", wren, pix_ready);
    end
  endtask

  task automatic test_out_of_range();
    pix_valid = 1'b1; pix_x = 9'd320; pix_y = 8'd5; pix_color = 8'hBB;
    @(negedge CLK);
    n_checks++;
    if (wren !== 1'b0 || pix_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_x got wren=%b ready=%b expected wren=0 ready=1", wren, pix_ready);
    end
    pix_x = 9'd0; pix_y = 8'd200;
    @(negedge CLK);
    n_checks++;
    if (wren !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_y got wren=%b expected 0", wren);
    end
    pix_x = 9'd10; pix_y = 8'd2; pix_color = 8'h5A;
    push_wr(650, 8'h5A);
    @(negedge CLK);
    n_checks++;
    if (wren !== 1'b1) begin
      n_fail++;
      $display("FAIL after_oor got wren=%b expected 1", wren);
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int  x  = $urandom_range(0, 330);
      int  y  = $urandom_range(0, 205);
      int  c  = $urandom_range(0, 255);
      logic ok;
      ok = (x < 320) && (y < 200);
      pix_valid = 1'b1; pix_x = 9'(x); pix_y = 8'(y); pix_color = 8'(c);
      FrameComplete = (i == 20);
      if (ok) push_wr(y * 320 + x, c);
      @(negedge CLK);
      n_checks++;
      if (wren !== ok || pix_ready !== 1'b1 || switch_buffer !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b i=%0d x=%0d y=%0d got wren=%b ready=%b switch=%b expected wren=%b ready=1 switch=0",
                 i, x, y, wren, pix_ready, switch_buffer, ok);
      end
    end
    FrameComplete = 1'b0;
    pix_valid = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_swap();
    pix_valid = 1'b1; pix_x = 9'd10; pix_y = 8'd2; pix_color = 8'h07; frame_done = 1'b1;
    push_wr(650, 8'h07);
    @(negedge CLK);
    n_checks++;
    if ({wren, pix_ready, drawing, switch_buffer} !== 4'b1001) begin
      n_fail++;
      $display("FAIL frame_done_hs got wren/ready/drawing/switch=%b expected 1001",
               {wren, pix_ready, drawing, switch_buffer});
    end
    frame_done = 1'b0; pix_x = 9'd1; pix_y = 8'd1; pix_color = 8'hCC;
    for (int i = 0; i < 500; i++) begin
      frame_done = (i == 10);
      @(negedge CLK);
      n_checks++;
      if ({wren, pix_ready, drawing, switch_buffer} !== 4'b0001) begin
        n_fail++;
        $display("FAIL swap_wait cycle=%0d got wren/ready/drawing/switch=%b expected 0001",
                 i, {wren, pix_ready, drawing, switch_buffer});
      end
    end
    frame_done = 1'b0;
    clear_color = 8'h42; FrameComplete = 1'b1;
    @(negedge CLK);
    FrameComplete = 1'b0; clear_color = 8'h99;
    n_checks++;
    if ({wren, pix_ready, drawing, switch_buffer} !== 4'b0000) begin
      n_fail++;
      $display("FAIL swap_exit got wren/ready/drawing/switch=%b expected 0000",
               {wren, pix_ready, drawing, switch_buffer});
    end
    for (int i = 0; i < 1000; i++) push_wr(i, 8'h42);
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      n_checks++;
      if ({wren, pix_ready, drawing, switch_buffer} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reclear_ctl cycle=%0d got wren/ready/drawing/switch=%b expected 1000",
                 i, {wren, pix_ready, drawing, switch_buffer});
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    RESET = 1'b1; clear_color = 8'h77;
    @(negedge CLK);
    n_checks++;
    if ({wren, pix_ready, drawing, switch_buffer} !== 4'b0000 || write_addr !== 16'd0 || frame_buffer_data !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset got ctl=%b addr=%0d data=%h expected ctl=0000 addr=0 data=00",
               {wren, pix_ready, drawing, switch_buffer}, write_addr, frame_buffer_data);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reclear_count got %0d pending writes expected 0", exp_q.size());
    end
    RESET = 1'b0;
    for (int i = 0; i < 50; i++) push_wr(i, 8'h77);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      n_checks++;
      if (wren !== 1'b1 || pix_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL restart_ctl cycle=%0d got wren=%b ready=%b expected wren=1 ready=0", i, wren, pix_ready);
      end
    end
    pix_valid = 1'b0;
    @(posedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart_count got %0d pending writes expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_draw();
    test_out_of_range();
    test_back_to_back();
    test_swap();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
